// File: rtl/onn_settle_ctrl.sv
// Settle sequencer for the 3x5 ONN phase registers: issues drop/state_cheak strobes
// and declares convergence after STABLE_CHECKS quiet checks. Optional: ONN_TIMEOUT_EN.
module onn_settle_ctrl #(
    parameter int unsigned N_NEURONS     = 15,
    parameter int unsigned PERIOD        = 16,
    parameter int unsigned STABLE_CHECKS = 3,
    parameter int unsigned ITER_W        = 8
`ifdef ONN_TIMEOUT_EN
    ,
    parameter int unsigned MAX_ITER      = 255
`endif
) (
    input  logic                 clk,
    input  logic                 re,
    input  logic                 start,
    input  logic [N_NEURONS-1:0] state_changed,
    output logic                 drop,
    output logic                 state_cheak,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [ITER_W-1:0]    iter_cnt
`ifdef ONN_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int unsigned PCNT_W = $clog2(PERIOD);
    localparam int unsigned STAB_W = $clog2(STABLE_CHECKS + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 2);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CHECKS - 1);
    localparam logic [ITER_W-1:0] ITER_SAT  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_EVAL  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state, state_d;
    logic [PCNT_W-1:0]   pcnt, pcnt_d;
    logic [STAB_W-1:0]   stab, stab_d;
    logic [ITER_W-1:0]   iter_d, iter_inc;
    logic                conv_d;
    logic                launch;
    logic                any_chg;
`ifdef ONN_TIMEOUT_EN
    logic                tmo_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        pcnt_d   = pcnt;
        stab_d   = stab;
        iter_d   = iter_cnt;
        conv_d   = converged;
        launch   = 1'b0;
        any_chg  = |state_changed;
        iter_inc = (iter_cnt == ITER_SAT) ? iter_cnt : iter_cnt + ITER_W'(1);
`ifdef ONN_TIMEOUT_EN
        tmo_d    = timeout;
`endif

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    launch = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                pcnt_d  = '0;
            end
            S_WAIT: begin
                if (pcnt == PCNT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    pcnt_d = pcnt + PCNT_W'(1);
                end
            end
            S_CHECK: begin
                state_d = S_EVAL;
                pcnt_d  = '0;
            end
            S_EVAL: begin
                stab_d = any_chg ? '0 : stab + STAB_W'(1);
                iter_d = iter_inc;
                if (!any_chg && (stab == STAB_LAST)) begin
                    state_d = S_DONE;
                    conv_d  = 1'b1;
                end
`ifdef ONN_TIMEOUT_EN
                else if (iter_inc == ITER_W'(MAX_ITER)) begin
                    state_d = S_DONE;
                    conv_d  = 1'b0;
                    tmo_d   = 1'b1;
                end
`endif
                else if (PCNT_LAST == '0) begin
                    state_d = S_CHECK;
                end else begin
                    // EVAL itself is period slot 0, so the wait resumes at 1
                    state_d = S_WAIT;
                    pcnt_d  = PCNT_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    launch = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Run launch: all run status is cleared on entry to LOAD
        if (launch) begin
            state_d = S_LOAD;
            pcnt_d  = '0;
            stab_d  = '0;
            iter_d  = '0;
            conv_d  = 1'b0;
`ifdef ONN_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (re) begin
            state       <= S_IDLE;
            pcnt        <= '0;
            stab        <= '0;
            drop        <= 1'b0;
            state_cheak <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            iter_cnt    <= '0;
`ifdef ONN_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            pcnt        <= pcnt_d;
            stab        <= stab_d;
            drop        <= (state_d == S_LOAD);
            state_cheak <= (state_d == S_CHECK);
            busy        <= (state_d == S_LOAD) || (state_d == S_WAIT) ||
                           (state_d == S_CHECK) || (state_d == S_EVAL);
            done        <= (state_d == S_DONE);
            converged   <= conv_d;
            iter_cnt    <= iter_d;
`ifdef ONN_TIMEOUT_EN
            timeout     <= tmo_d;
`endif
        end
    end

endmodule
